// File: rtl/ads131_frame_deserializer.sv
`timescale 1ns/1ps
// ads131_frame_deserializer
// Samples the ADS131A0x MISO line on SPI clock falling edges (CPHA=1) inside
// the enable window and assembles MSB-first 32-bit words. Word 0 is the
// status/response word. In a data frame it is followed by NUM_CH channel words.
// A completed frame is staged and then copied to the outputs in a single cycle,
// so downstream logic never sees a mix of two frames.
// The ch_data_0..3 ports assume NUM_CH = 4.
module ads131_frame_deserializer #(
    parameter int WORD_BITS   = 32,
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        input_clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        adc_init_completed_status,
    input  logic        spi_sclk,
    input  logic        spi_miso,
    output logic [15:0] status_word,
    output logic [23:0] ch_data_0,
    output logic [23:0] ch_data_1,
    output logic [23:0] ch_data_2,
    output logic [23:0] ch_data_3,
    output logic        frame_valid,
    output logic        frame_abort,
    output logic        overrun,
    output logic [15:0] frame_count
);

    localparam int BW = $clog2(WORD_BITS);
    localparam int IW = $clog2(NUM_CH + 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0]   miso_sync;
    logic                     miso_s;
    logic                     sclk_d;
    logic                     enable_d;
    logic                     fall;
    logic                     enable_rise;

    // The top bit of each word is never needed after the word completes, so
    // only WORD_BITS-1 bits of history are kept. On the final fall of a word
    // the top 24 bits of the completed word are all in this register already;
    // the bit arriving on that fall is pad.
    logic [WORD_BITS-2:0]     shift_reg;
    logic [23:0]              word_top;
    logic [BW-1:0]            bit_cnt;
    logic [IW-1:0]            word_idx;
    logic [IW-1:0]            words_expected;
    logic [15:0]              stage_status;
    logic [NUM_CH-1:0][23:0]  stage_ch;
    logic [NUM_CH-1:0][23:0]  ch_q;
    logic                     commit_pend;

    // Control strobes decoded from the FSM state.
    logic start;
    logic sample;
    logic word_end;
    logic frame_end;
    logic abort;

    assign miso_s      = miso_sync[SYNC_STAGES-1];
    assign fall        = sclk_d & ~spi_sclk & enable;
    assign enable_rise = enable & ~enable_d;
    assign word_top    = shift_reg[WORD_BITS-2 -: 24];

    assign ch_data_0 = ch_q[0];
    assign ch_data_1 = ch_q[1];
    assign ch_data_2 = ch_q[2];
    assign ch_data_3 = ch_q[3];

    // MISO synchronizer chain and edge-detect history flops.
    always_ff @(posedge input_clock or negedge reset_n) begin
        if (!reset_n) begin
            miso_sync <= '0;
            sclk_d    <= 1'b0;
            enable_d  <= 1'b0;
        end else begin
            miso_sync <= {miso_sync[SYNC_STAGES-2:0], spi_miso};
            sclk_d    <= spi_sclk;
            enable_d  <= enable;
        end
    end

    // FSM state register.
    always_ff @(posedge input_clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // FSM next-state logic. Losing enable during SHIFT is an abort; losing
    // it in DONE is the normal end of the window.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable_rise) state_nx = SHIFT;
            SHIFT: begin
                if (!enable)        state_nx = IDLE;
                else if (frame_end) state_nx = DONE;
            end
            DONE:    if (!enable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM output decode. Falls are only sampled in SHIFT, so an edge left over
    // from a previous window that coincides with the enable rise is ignored.
    always_comb begin
        start     = 1'b0;
        sample    = 1'b0;
        word_end  = 1'b0;
        frame_end = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE:  start = enable_rise;
            SHIFT: begin
                sample    = fall;
                word_end  = fall && (bit_cnt == LAST_BIT);
                frame_end = word_end && (word_idx == words_expected - IW'(1));
                abort     = !enable;
            end
            default: ;
        endcase
    end

    // Shift register, bit/word counters and staging slots.
    always_ff @(posedge input_clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg      <= '0;
            bit_cnt        <= '0;
            word_idx       <= '0;
            words_expected <= '0;
            stage_status   <= '0;
            stage_ch       <= '0;
        end else if (start) begin
            bit_cnt        <= '0;
            word_idx       <= '0;
            words_expected <= adc_init_completed_status ? IW'(NUM_CH + 1) : IW'(1);
        end else if (sample) begin
            shift_reg <= {shift_reg[WORD_BITS-3:0], miso_s};
            if (word_end) begin
                bit_cnt  <= '0;
                word_idx <= word_idx + IW'(1);
                if (word_idx == '0) stage_status <= word_top[23:8];
                for (int i = 0; i < NUM_CH; i++) begin
                    if (word_idx == IW'(i + 1)) stage_ch[i] <= word_top;
                end
            end else begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    // Commit request: one cycle after the final word lands in staging.
    always_ff @(posedge input_clock or negedge reset_n) begin
        if (!reset_n) commit_pend <= 1'b0;
        else          commit_pend <= frame_end;
    end

    // Output registers: atomic frame update, strobes and frame counter.
    // words_expected cannot change between frame_end and the commit because
    // the FSM is in DONE for that cycle.
    always_ff @(posedge input_clock or negedge reset_n) begin
        if (!reset_n) begin
            status_word <= '0;
            ch_q        <= '0;
            frame_valid <= 1'b0;
            frame_abort <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_abort <= abort;
            if (commit_pend) begin
                status_word <= stage_status;
                if (words_expected != IW'(1)) ch_q <= stage_ch;
                frame_valid <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Sticky overrun: any fall after the frame completed, cleared at frame start.
    always_ff @(posedge input_clock or negedge reset_n) begin
        if (!reset_n)                   overrun <= 1'b0;
        else if (start)                 overrun <= 1'b0;
        else if (state == DONE && fall) overrun <= 1'b1;
    end

endmodule
